// File: rtl/pong_referee_if.sv
// pong_referee_if: signal bundle between the pong referee and the rest of the
// game (ball/paddle position sources on one side, Ball FSM and score display on
// the other).
//
//   new_game    1-cycle pulse: clear scores, leave GAME_OVER
//   ball_x/y    ball top-left position (10 bits each)
//   ball_w/h    ball size (8 bits each)
//   paddle_l_y  left paddle top y
//   paddle_r_y  right paddle top y
//   bounce      bounce code to the Ball: 00 none, 01 paddle, 10 wall, 11 scored
//   score_l/r   player scores
//   point       1-cycle pulse: 01 left scored, 10 right scored
//   game_over   high while the game is over
//   fsm_state   referee FSM state, for debug/observation only
//
// Handshake: bounce acts as a "valid" that the referee holds steady until the
// Ball has acted on it. The Ball never raises a ready signal; consumption is
// inferred from the ball position leaving the latched contact position. After
// consumption bounce drops to 00 on the next cycle and is never re-raised for
// the same contact.
//
// master: drives positions and new_game, observes referee outputs.
// slave : the referee itself.
interface pong_referee_if;
  logic       new_game;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] ball_w;
  logic [7:0] ball_h;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [1:0] bounce;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] point;
  logic       game_over;
  logic [2:0] fsm_state;

  modport master (
    output new_game, ball_x, ball_y, ball_w, ball_h, paddle_l_y, paddle_r_y,
    input  bounce, score_l, score_r, point, game_over, fsm_state
  );

  modport slave (
    input  new_game, ball_x, ball_y, ball_w, ball_h, paddle_l_y, paddle_r_y,
    output bounce, score_l, score_r, point, game_over, fsm_state
  );
endinterface

// File: rtl/pong_referee.sv
// pong_referee: collision and score referee placed directly upstream of the
// Ball FSM. Detects goal, paddle and wall contacts from the ball and paddle
// positions, presents a registered 2-bit bounce code to the Ball and holds it
// until the Ball has moved, keeps both scores and flags game over.
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high; overrides everything
//   bus    pong_referee_if.slave (positions and new_game in; bounce, scores,
//          point, game_over and debug fsm_state out)
module pong_referee #(
  parameter int SCREEN_X   = 640,
  parameter int SCREEN_Y   = 480,
  parameter int PADDLE_L_X = 16,
  parameter int PADDLE_R_X = 616,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int MAX_SCORE  = 9
) (
  input  logic          clock,
  input  logic          reset,
  pong_referee_if.slave bus
);

  typedef enum logic [2:0] {
    ST_PLAY      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_COOLDOWN  = 3'd2,
    ST_SCORE     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_PAD  = 2'b01;
  localparam logic [1:0] CODE_WALL = 2'b10;
  localparam logic [1:0] CODE_GOAL = 2'b11;

  localparam logic [10:0] SX       = 11'(SCREEN_X);
  localparam logic [10:0] SY       = 11'(SCREEN_Y);
  localparam logic [10:0] PL_LEFT  = 11'(PADDLE_L_X);
  localparam logic [10:0] PL_RIGHT = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] PR_LEFT  = 11'(PADDLE_R_X);
  localparam logic [10:0] PR_RIGHT = 11'(PADDLE_R_X + PADDLE_W);
  localparam logic [10:0] PH       = 11'(PADDLE_H);
  localparam logic [3:0]  MAX      = 4'(MAX_SCORE);

  // ---------------------------------------------------------------------
  // Contact terms. All edges are 11-bit so x+w / y+h never overflow; a ball
  // that was decremented past 0 wraps to a large value and reads as "beyond".
  // ---------------------------------------------------------------------
  logic [10:0] x_lo, x_hi, y_lo, y_hi;
  logic [10:0] pl_top, pl_bot, pr_top, pr_bot;
  logic        goal_l, goal_r, goal, pad_l, pad_r, pad, wall;

  assign x_lo   = {1'b0, bus.ball_x};
  assign y_lo   = {1'b0, bus.ball_y};
  assign x_hi   = x_lo + {3'b000, bus.ball_w};
  assign y_hi   = y_lo + {3'b000, bus.ball_h};
  assign pl_top = {1'b0, bus.paddle_l_y};
  assign pr_top = {1'b0, bus.paddle_r_y};
  assign pl_bot = pl_top + PH;
  assign pr_bot = pr_top + PH;

  assign goal_l = (bus.ball_x == 10'd0) || (x_lo > SX);
  assign goal_r = (x_hi >= SX) && (x_lo <= SX);
  assign goal   = goal_l || goal_r;
  assign pad_l  = (x_lo < PL_RIGHT) && (x_hi > PL_LEFT) &&
                  (y_lo < pl_bot) && (y_hi > pl_top);
  assign pad_r  = (x_lo < PR_RIGHT) && (x_hi > PR_LEFT) &&
                  (y_lo < pr_bot) && (y_hi > pr_top);
  assign pad    = pad_l || pad_r;
  assign wall   = (bus.ball_y == 10'd0) || (y_lo > SY) || (y_hi >= SY);

  // Highest-priority class present this cycle: GOAL > PAD > WALL.
  logic [1:0] event_code;
  assign event_code = goal ? CODE_GOAL :
                      pad  ? CODE_PAD  :
                      wall ? CODE_WALL : CODE_NONE;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t      state, next_state;
  logic [1:0]  code_q;      // class of the contact being held / cooled down
  logic [19:0] pos_q;       // {ball_x, ball_y} at the moment of the contact
  logic        side_l_q;    // held goal was on the left edge
  logic [1:0]  bounce_q, bounce_d;
  logic [1:0]  point_q, point_d;
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;

  logic        take;        // accept a new contact into HOLD this cycle
  logic [1:0]  take_code;
  logic [1:0]  cool_code;   // contact acceptable while cooling down
  logic        cool_term;   // the suppressed class is still in contact
  logic        consumed;
  logic        at_max;

  // In COOLDOWN the suppressed class is judged on its own term, not on the
  // prioritised code, so a wall hit hidden behind a paddle hit still gets in.
  always_comb begin
    cool_code = CODE_NONE;
    if (goal)                             cool_code = CODE_GOAL;
    else if (pad  && code_q != CODE_PAD)  cool_code = CODE_PAD;
    else if (wall && code_q != CODE_WALL) cool_code = CODE_WALL;
  end

  always_comb begin
    case (code_q)
      CODE_PAD:  cool_term = pad;
      CODE_WALL: cool_term = wall;
      CODE_GOAL: cool_term = goal;
      default:   cool_term = 1'b0;
    endcase
  end

  assign consumed = ({bus.ball_x, bus.ball_y} != pos_q);
  assign at_max   = ((score_l_q == MAX) || (score_r_q == MAX)) && !bus.new_game;

  // Process 1: state register (plus the registers it steers)
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_PLAY;
      code_q    <= CODE_NONE;
      pos_q     <= 20'd0;
      side_l_q  <= 1'b0;
      bounce_q  <= CODE_NONE;
      point_q   <= 2'b00;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
    end else begin
      state     <= next_state;
      bounce_q  <= bounce_d;
      point_q   <= point_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      if (take) begin
        code_q   <= take_code;
        pos_q    <= {bus.ball_x, bus.ball_y};
        side_l_q <= goal_l;
      end
    end
  end

  // Process 2: next-state logic
  always_comb begin
    next_state = state;
    take       = 1'b0;
    take_code  = CODE_NONE;
    case (state)
      ST_PLAY: begin
        if (event_code != CODE_NONE) begin
          take       = 1'b1;
          take_code  = event_code;
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (consumed) next_state = (code_q == CODE_GOAL) ? ST_SCORE : ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cool_code != CODE_NONE) begin
          take       = 1'b1;
          take_code  = cool_code;
          next_state = ST_HOLD;
        end else if (!cool_term) begin
          next_state = ST_PLAY;
        end
      end
      ST_SCORE: begin
        // Scores were already updated on entry, so compare them directly.
        next_state = at_max ? ST_GAME_OVER : ST_COOLDOWN;
      end
      ST_GAME_OVER: begin
        if (bus.new_game) next_state = ST_PLAY;
      end
      default: next_state = ST_PLAY;
    endcase
  end

  // Process 3: output logic (next values of the registered outputs)
  always_comb begin
    bounce_d  = CODE_NONE;
    point_d   = 2'b00;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (next_state == ST_HOLD) bounce_d = take ? take_code : code_q;
    // Award on the transition into SCORE so point and the new score appear
    // together during the SCORE cycle.
    if (state == ST_HOLD && next_state == ST_SCORE) begin
      if (side_l_q) begin
        point_d = 2'b10;
        if (score_r_q < MAX) score_r_d = score_r_q + 4'd1;
      end else begin
        point_d = 2'b01;
        if (score_l_q < MAX) score_l_d = score_l_q + 4'd1;
      end
    end
    if (bus.new_game) begin
      score_l_d = 4'd0;
      score_r_d = 4'd0;
    end
  end

  assign bus.bounce    = bounce_q;
  assign bus.point     = point_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.game_over = (state == ST_GAME_OVER);
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_pong_referee.sv
// tb_pong_referee: directed bench for pong_referee. A behavioural model of
// the referee rules runs alongside the DUT and is compared every cycle; a set
// of hand-computed literal expectations pins the model to the intended
// behaviour at key points.
module tb_pong_referee;

  localparam int MAX = 9;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  pong_referee_if bus ();

  pong_referee dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit pad_hit(int bx, int by, int bw, int bh, int px, int py);
    return (bx < px + 8) && (bx + bw > px) && (by < py + 64) && (by + bh > py);
  endfunction

  bit m_valid, m_hold, m_gap, m_over, m_side_l;
  int m_cool;                 // class currently suppressed, 0 = none
  int m_code, m_px, m_py;
  int e_bounce, e_point, e_sl, e_sr, e_go;

  initial begin
    m_valid = 0; m_hold = 0; m_gap = 0; m_over = 0; m_side_l = 0;
    m_cool = 0; m_code = 0; m_px = 0; m_py = 0;
    e_bounce = 0; e_point = 0; e_sl = 0; e_sr = 0; e_go = 0;
  end

  always @(posedge clock) begin : model
    int bx, by, bw, bh, acc;
    bit gl, gr, pd, wl;
    bx = int'(bus.ball_x); by = int'(bus.ball_y);
    bw = int'(bus.ball_w); bh = int'(bus.ball_h);
    if (reset) begin
      m_valid = 1; m_hold = 0; m_gap = 0; m_over = 0; m_cool = 0;
      e_point = 0; e_sl = 0; e_sr = 0;
    end else begin
      gl  = (bx == 0) || (bx > 640);
      gr  = (bx + bw >= 640) && (bx <= 640);
      pd  = pad_hit(bx, by, bw, bh, 16, int'(bus.paddle_l_y)) ||
            pad_hit(bx, by, bw, bh, 616, int'(bus.paddle_r_y));
      wl  = (by == 0) || (by > 480) || (by + bh >= 480);
      acc = 0;
      e_point = 0;
      if (m_over) begin
        if (bus.new_game) m_over = 0;
      end else if (m_gap) begin
        m_gap = 0;
        if ((e_sl == MAX || e_sr == MAX) && !bus.new_game) m_over = 1;
      end else if (m_hold) begin
        if (bx != m_px || by != m_py) begin
          m_hold = 0;
          m_cool = m_code;
          if (m_code == 3) begin
            m_gap = 1;
            if (m_side_l) begin e_point = 2; if (e_sr < MAX) e_sr++; end
            else          begin e_point = 1; if (e_sl < MAX) e_sl++; end
          end
        end
      end else if (m_cool != 0) begin
        if (gl || gr)                acc = 3;
        else if (pd && m_cool != 1)  acc = 1;
        else if (wl && m_cool != 2)  acc = 2;
        else if (!((m_cool == 1) ? pd : (m_cool == 2) ? wl : (gl || gr))) m_cool = 0;
      end else begin
        acc = (gl || gr) ? 3 : pd ? 1 : wl ? 2 : 0;
      end
      if (acc != 0) begin
        m_hold = 1; m_code = acc; m_px = bx; m_py = by; m_side_l = gl;
      end
      if (bus.new_game) begin e_sl = 0; e_sr = 0; end
    end
    e_bounce = m_hold ? m_code : 0;
    e_go     = m_over;
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_bounce",    32'(bus.bounce),    32'(e_bounce));
      chk("model_point",     32'(bus.point),     32'(e_point));
      chk("model_score_l",   32'(bus.score_l),   32'(e_sl));
      chk("model_score_r",   32'(bus.score_r),   32'(e_sr));
      chk("model_game_over", 32'(bus.game_over), 32'(e_go));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ball(input int x, input int y);
    bus.ball_x = 10'(x);
    bus.ball_y = 10'(y);
  endtask

  task automatic neutral();
    set_ball(320, 240);
  endtask

  // Score one goal with the ball at (x,200) and return to PLAY.
  task automatic score_goal(input int x);
    set_ball(x, 200);
    ticks(2);
    neutral();
    ticks(3);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.new_game   = 1'b0;
    bus.ball_w     = 8'd8;
    bus.ball_h     = 8'd8;
    bus.paddle_l_y = 10'd200;
    bus.paddle_r_y = 10'd200;
    neutral();
    ticks(2);
    chk("reset_bounce",    32'(bus.bounce),    0);
    chk("reset_scores",    32'({bus.score_l, bus.score_r}), 0);
    chk("reset_game_over", 32'(bus.game_over), 0);
    reset = 1'b0;
    tick();
    chk("idle_bounce", 32'(bus.bounce), 0);

    // 1: left paddle hit, held while static, released after a move
    bus.paddle_l_y = 10'd90;
    set_ball(20, 100);
    tick();
    chk("t1_pad", 32'(bus.bounce), 1);
    ticks(2);
    chk("t1_pad_held", 32'(bus.bounce), 1);
    set_ball(21, 101);
    tick();
    chk("t1_consumed", 32'(bus.bounce), 0);
    neutral();
    ticks(2);

    // 2: top wall, cooldown suppresses repeat until the term clears
    set_ball(300, 0);
    tick();
    chk("t2_wall", 32'(bus.bounce), 2);
    set_ball(301, 0);
    ticks(2);
    chk("t2_cooldown", 32'(bus.bounce), 0);
    set_ball(301, 1);
    tick();
    set_ball(301, 0);
    tick();
    chk("t2_rewall", 32'(bus.bounce), 2);
    neutral();
    ticks(3);

    // 3: left goal -> right scores
    bus.paddle_l_y = 10'd0;
    set_ball(0, 200);
    ticks(2);
    chk("t3_goal_held", 32'(bus.bounce), 3);
    neutral();
    tick();
    chk("t3_point",   32'(bus.point),   2);
    chk("t3_score_r", 32'(bus.score_r), 1);
    tick();
    chk("t3_point_pulse", 32'(bus.point), 0);
    ticks(2);

    // 4: right goals until the left player wins
    for (int i = 0; i < 8; i++) score_goal(632);
    chk("t4_score_l_8", 32'(bus.score_l), 8);
    set_ball(632, 200);
    tick();
    chk("t4_goal", 32'(bus.bounce), 3);
    neutral();
    tick();
    chk("t4_score_l_9", 32'(bus.score_l), 9);
    tick();
    chk("t4_game_over", 32'(bus.game_over), 1);
    set_ball(0, 0);
    ticks(2);
    chk("t4_ignored", 32'(bus.bounce), 0);
    neutral();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    chk("t4_new_game_go",    32'(bus.game_over), 0);
    chk("t4_new_game_score", 32'({bus.score_l, bus.score_r}), 0);
    tick();

    // 5: corner, paddle beats wall, then wall accepted from cooldown
    set_ball(20, 0);
    tick();
    chk("t5_pad_first", 32'(bus.bounce), 1);
    set_ball(21, 0);
    tick();
    chk("t5_gap", 32'(bus.bounce), 0);
    tick();
    chk("t5_wall_next", 32'(bus.bounce), 2);
    neutral();
    ticks(3);

    // 7: boundary cases
    set_ball(300, 471);
    tick();
    chk("t7_no_floor", 32'(bus.bounce), 0);
    set_ball(300, 472);
    tick();
    chk("t7_floor", 32'(bus.bounce), 2);
    neutral();
    ticks(3);
    bus.paddle_l_y = 10'd90;
    set_ball(24, 100);
    tick();
    chk("t7_pad_edge_miss", 32'(bus.bounce), 0);
    set_ball(641, 200);
    tick();
    chk("t7_wrap_goal", 32'(bus.bounce), 3);
    neutral();
    ticks(3);

    // 6: reset in the middle of a paddle HOLD
    score_goal(632);
    set_ball(20, 100);
    tick();
    chk("t6_pad", 32'(bus.bounce), 1);
    reset = 1'b1;
    tick();
    chk("t6_reset_bounce", 32'(bus.bounce), 0);
    chk("t6_reset_scores", 32'({bus.score_l, bus.score_r}), 0);
    chk("t6_reset_point",  32'(bus.point), 0);
    reset = 1'b0;
    neutral();
    ticks(2);
    chk("t6_scores_after", 32'({bus.score_l, bus.score_r}), 0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
